// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle MIPS CPU.
// Holds the multiply/divide sequencer state encoding and op encoding.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_RUN  = 3'd2,
        ST_LOAD = 3'd3,
        ST_EXC  = 3'd4
    } md_state_t;

    // Op encoding doubles as the hi/lo mux select (0 = div, 1 = mult).
    typedef logic md_op_t;
    localparam md_op_t OP_DIV  = 1'b0;
    localparam md_op_t OP_MULT = 1'b1;

    localparam int MULT_CYCLES_DEF = 32;
    localparam int DIV_CYCLES_DEF  = 32;
    localparam int CNT_W_DEF       = 6;

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Loadable down-counter with a zero flag.
// Holds at zero rather than wrapping if decremented there.
module muldiv_cycle_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multicycle multiply/divide unit: clears, runs,
// then loads Hi/Lo, or raises a divide-by-zero exception.
module muldiv_ctrl
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic mult_req,
    input  logic div_req,
    input  logic divisor_zero,
    input  logic abort,
    output logic unit_clr,
    output logic mult_run,
    output logic div_run,
    output logic sel_mux_hi,
    output logic sel_mux_lo,
    output logic HiLo_load,
    output logic busy,
    output logic done,
    output logic div_zero
);

    localparam logic [CNT_W-1:0] MULT_PRE = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_PRE  = CNT_W'(DIV_CYCLES - 1);

    md_state_t state;
    md_state_t state_nxt;
    md_op_t    op;
    md_op_t    op_nxt;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign cnt_val = (op == OP_MULT) ? MULT_PRE : DIV_PRE;

    muldiv_cycle_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            op    <= OP_DIV;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
        end
    end

    // Abort only cancels before the result commits (CLR/RUN).
    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        unique case (state)
            ST_IDLE: begin
                if (!abort) begin
                    if (mult_req) begin
                        state_nxt = ST_CLR;
                        op_nxt    = OP_MULT;
                    end else if (div_req && !divisor_zero) begin
                        state_nxt = ST_CLR;
                        op_nxt    = OP_DIV;
                    end else if (div_req) begin
                        state_nxt = ST_EXC;
                    end
                end
            end
            ST_CLR: begin
                state_nxt = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_zero) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: state_nxt = ST_IDLE;
            ST_EXC:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        unit_clr  = 1'b0;
        mult_run  = 1'b0;
        div_run   = 1'b0;
        HiLo_load = 1'b0;
        done      = 1'b0;
        div_zero  = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        unique case (state)
            ST_IDLE: ;
            ST_CLR: begin
                unit_clr = 1'b1;
                cnt_load = 1'b1;
            end
            ST_RUN: begin
                mult_run = (op == OP_MULT);
                div_run  = (op == OP_DIV);
                cnt_dec  = 1'b1;
            end
            ST_LOAD: begin
                HiLo_load = 1'b1;
                done      = 1'b1;
            end
            ST_EXC: begin
                div_zero = 1'b1;
            end
            default: ;
        endcase
    end

    assign sel_mux_hi = op;
    assign sel_mux_lo = op;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: default-parameter instance plus
// a short-cycle instance (MULT_CYCLES=1, DIV_CYCLES=5).
module tb_muldiv_ctrl;

    typedef struct {
        int   busy_n;
        int   clr_n;
        int   mrun_n;
        int   drun_n;
        int   load_n;
        int   done_n;
        int   dz_n;
        logic sel;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mreq, dreq, dzero, abrt;
    logic [1:0] clr, mrun, drun, shi, slo, hl, busy, done, dz;

    int   total = 0;
    int   bad   = 0;
    txn_t q0[$];
    txn_t q1[$];

    int   n_busy[2], n_clr[2], n_mrun[2], n_drun[2];
    int   n_load[2], n_done[2], n_dz[2];
    logic s_hi[2], s_lo[2];

    always #5 clk = ~clk;

    muldiv_ctrl u0 (
        .clk(clk), .reset(reset),
        .mult_req(mreq[0]), .div_req(dreq[0]),
        .divisor_zero(dzero[0]), .abort(abrt[0]),
        .unit_clr(clr[0]), .mult_run(mrun[0]), .div_run(drun[0]),
        .sel_mux_hi(shi[0]), .sel_mux_lo(slo[0]),
        .HiLo_load(hl[0]), .busy(busy[0]), .done(done[0]),
        .div_zero(dz[0])
    );

    muldiv_ctrl #(
        .MULT_CYCLES(1), .DIV_CYCLES(5), .CNT_W(6)
    ) u1 (
        .clk(clk), .reset(reset),
        .mult_req(mreq[1]), .div_req(dreq[1]),
        .divisor_zero(dzero[1]), .abort(abrt[1]),
        .unit_clr(clr[1]), .mult_run(mrun[1]), .div_run(drun[1]),
        .sel_mux_hi(shi[1]), .sel_mux_lo(slo[1]),
        .HiLo_load(hl[1]), .busy(busy[1]), .done(done[1]),
        .div_zero(dz[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input int b, input int c, input int m,
                                input int dv, input int l, input int dn,
                                input int z, input logic s);
        txn_t t;
        t.busy_n = b;
        t.clr_n  = c;
        t.mrun_n = m;
        t.drun_n = dv;
        t.load_n = l;
        t.done_n = dn;
        t.dz_n   = z;
        t.sel    = s;
        return t;
    endfunction

    task automatic push(input int d, input txn_t t);
        if (d == 0) q0.push_back(t);
        else q1.push_back(t);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Monitor: accumulate per-op activity while busy, score it when busy drops.
    always @(negedge clk) begin
        txn_t e;
        if (reset) begin
            q0.delete();
            q1.delete();
            for (int d = 0; d < 2; d++) begin
                n_busy[d] = 0; n_clr[d] = 0; n_mrun[d] = 0; n_drun[d] = 0;
                n_load[d] = 0; n_done[d] = 0; n_dz[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (busy[d]) begin
                    n_busy[d]++;
                    n_clr[d]  += int'(clr[d]);
                    n_mrun[d] += int'(mrun[d]);
                    n_drun[d] += int'(drun[d]);
                    n_load[d] += int'(hl[d]);
                    n_done[d] += int'(done[d]);
                    n_dz[d]   += int'(dz[d]);
                    s_hi[d] = shi[d];
                    s_lo[d] = slo[d];
                end else begin
                    chk($sformatf("dut%0d idle_quiet", d),
                        int'({clr[d], mrun[d], drun[d], hl[d], done[d], dz[d]}), 0);
                    if (n_busy[d] > 0) begin
                        if (qsize(d) == 0) begin
                            total++;
                            bad++;
                            $display("FAIL dut%0d unexpected_op: got op busy=%0d expected none",
                                     d, n_busy[d]);
                        end else begin
                            if (d == 0) e = q0.pop_front();
                            else e = q1.pop_front();
                            chk($sformatf("dut%0d busy_cycles", d), n_busy[d], e.busy_n);
                            chk($sformatf("dut%0d clr_cycles", d), n_clr[d], e.clr_n);
                            chk($sformatf("dut%0d mult_run_cycles", d), n_mrun[d], e.mrun_n);
                            chk($sformatf("dut%0d div_run_cycles", d), n_drun[d], e.drun_n);
                            chk($sformatf("dut%0d hilo_load_cycles", d), n_load[d], e.load_n);
                            chk($sformatf("dut%0d done_cycles", d), n_done[d], e.done_n);
                            chk($sformatf("dut%0d div_zero_cycles", d), n_dz[d], e.dz_n);
                            chk($sformatf("dut%0d sel_hi", d), int'(s_hi[d]), int'(e.sel));
                            chk($sformatf("dut%0d sel_lo", d), int'(s_lo[d]), int'(e.sel));
                        end
                        n_busy[d] = 0; n_clr[d] = 0; n_mrun[d] = 0; n_drun[d] = 0;
                        n_load[d] = 0; n_done[d] = 0; n_dz[d] = 0;
                    end
                end
            end
        end
    end

    task automatic pulse_req(input int d, input logic m, input logic dv, input logic z);
        @(posedge clk);
        #1;
        mreq[d] = m; dreq[d] = dv; dzero[d] = z;
        @(posedge clk);
        #1;
        mreq[d] = 1'b0; dreq[d] = 1'b0; dzero[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!busy[d] && qsize(d) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL dut%0d wait_idle: got busy=%0d pending=%0d expected idle",
                     d, busy[d], qsize(d));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mreq = '0; dreq = '0; dzero = '0; abrt = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("dut%0d reset_outputs", d),
                int'({clr[d], mrun[d], drun[d], shi[d], slo[d],
                      hl[d], busy[d], done[d], dz[d]}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Multiply, defaults.
        push(0, mk(34, 1, 32, 0, 1, 1, 0, 1'b1));
        pulse_req(0, 1'b1, 1'b0, 1'b0);
        wait_idle(0, 60);

        // Divide by zero: selects keep the previous op (mult).
        push(0, mk(1, 0, 0, 0, 0, 0, 1, 1'b1));
        pulse_req(0, 1'b0, 1'b1, 1'b1);
        wait_idle(0, 10);

        // Divide, nonzero divisor.
        push(0, mk(34, 1, 0, 32, 1, 1, 0, 1'b0));
        pulse_req(0, 1'b0, 1'b1, 1'b0);
        wait_idle(0, 60);

        // Simultaneous requests: multiply wins.
        push(0, mk(34, 1, 32, 0, 1, 1, 0, 1'b1));
        pulse_req(0, 1'b1, 1'b1, 1'b0);
        wait_idle(0, 60);

        // Divide request during RUN cycle 10 is dropped.
        push(0, mk(34, 1, 32, 0, 1, 1, 0, 1'b1));
        pulse_req(0, 1'b1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        dreq[0] = 1'b1;
        @(posedge clk);
        #1;
        dreq[0] = 1'b0;
        wait_idle(0, 60);

        // Abort at RUN cycle 5 of a divide.
        push(0, mk(6, 1, 0, 5, 0, 0, 0, 1'b0));
        pulse_req(0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        abrt[0] = 1'b1;
        @(posedge clk);
        #1;
        abrt[0] = 1'b0;
        wait_idle(0, 60);

        // Abort during LOAD still commits.
        push(0, mk(34, 1, 32, 0, 1, 1, 0, 1'b1));
        pulse_req(0, 1'b1, 1'b0, 1'b0);
        repeat (33) @(posedge clk);
        #1;
        abrt[0] = 1'b1;
        @(posedge clk);
        #1;
        abrt[0] = 1'b0;
        wait_idle(0, 60);

        // Abort in IDLE outranks a request.
        @(posedge clk);
        #1;
        abrt[0] = 1'b1;
        mreq[0] = 1'b1;
        @(posedge clk);
        #1;
        abrt[0] = 1'b0;
        mreq[0] = 1'b0;
        @(negedge clk);
        chk("dut0 idle_abort_busy", int'(busy[0]), 0);

        // Abort during EXC: the exception still commits.
        @(posedge clk);
        #1;
        push(0, mk(1, 0, 0, 0, 0, 0, 1, 1'b1));
        dreq[0] = 1'b1;
        dzero[0] = 1'b1;
        @(posedge clk);
        #1;
        dreq[0] = 1'b0;
        dzero[0] = 1'b0;
        abrt[0] = 1'b1;
        @(posedge clk);
        #1;
        abrt[0] = 1'b0;
        wait_idle(0, 10);

        // Reset mid-RUN: outputs drop before any clock edge.
        push(0, mk(34, 1, 32, 0, 1, 1, 0, 1'b1));
        pulse_req(0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("dut0 async_reset_outputs",
            int'({clr[0], mrun[0], drun[0], shi[0], slo[0],
                  hl[0], busy[0], done[0], dz[0]}), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("dut0 post_reset_busy", int'(busy[0]), 0);
        chk("dut0 post_reset_sel", int'(shi[0]), 0);

        // Short-cycle instance: 1 mult RUN cycle, 5 div RUN cycles.
        push(1, mk(3, 1, 1, 0, 1, 1, 0, 1'b1));
        pulse_req(1, 1'b1, 1'b0, 1'b0);
        wait_idle(1, 20);
        push(1, mk(7, 1, 0, 5, 1, 1, 0, 1'b0));
        pulse_req(1, 1'b0, 1'b1, 1'b0);
        wait_idle(1, 20);

        repeat (3) @(negedge clk);
        chk("dut0 scoreboard_drained", q0.size(), 0);
        chk("dut1 scoreboard_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the multicycle multiply/divide resource in the multicycle MIPS CPU. It accepts one-cycle requests from the main control unit and clears and runs the `mult` or `div` unit for a fixed iteration count. It then steers `mux_hi_select`/`mux_lo_select` and pulses `HiLo_load`, or raises a divide-by-zero exception instead. While busy it stalls the main controller.

## Interface
- `MULT_CYCLES`, 32: RUN cycles for multiply, ≥1.
- `DIV_CYCLES`, 32: RUN cycles for divide, ≥1.
- `CNT_W`, 6: counter width, must hold max(MULT_CYCLES, DIV_CYCLES).

Ports. One clock; `reset` is asynchronous and active-high.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `mult_req` in 1: start multiply of A×B; honoured only in IDLE.
- `div_req` in 1: start divide A÷B; honoured only in IDLE.
- `divisor_zero` in 1: B==0, sampled only when `div_req` is accepted.
- `abort` in 1: cancel in-flight op (exception in main control).
- `unit_clr` out 1: clears internal state of `mult` and `div`.
- `mult_run` out 1: enables one `mult` iteration per cycle.
- `div_run` out 1: enables one `div` iteration per cycle.
- `sel_mux_hi` out 1: 0 = DIV_hi, 1 = MULT_hi.
- `sel_mux_lo` out 1: 0 = DIV_lo, 1 = MULT_lo.
- `HiLo_load` out 1: write enable of Hi and Lo.
- `busy` out 1: state ≠ IDLE; main control must hold.
- `done` out 1: one-cycle completion pulse.
- `div_zero` out 1: one-cycle divide-by-zero exception pulse.

## Operation
States: IDLE, CLR, RUN, LOAD, EXC.
- IDLE:
  - `mult_req` → CLR, and latch op=MULT.
  - Else `div_req` with `divisor_zero`=0 → CLR, and latch op=DIV.
  - Else `div_req` with `divisor_zero`=1 → EXC.
  - Else stay in IDLE.
- CLR: `unit_clr`=1. Load counter with the op's cycle count minus 1. Go to RUN.
- RUN: `mult_run`=1 (op MULT) or `div_run`=1 (op DIV). Decrement counter. When counter==0, go to LOAD.
- LOAD: `HiLo_load`=1 and `done`=1. Go to IDLE.
- EXC: `div_zero`=1. No run, no `HiLo_load`. Op latch unchanged. Go to IDLE.
- `sel_mux_hi` = `sel_mux_lo` = latched op, driven in all states. The op latch retains its value after completion.
- All outputs are Moore outputs decoded from registered state/op; there is no combinational path from inputs.

Boundary rules:
- `mult_req` and `div_req` high together: multiply wins; the divide is dropped.
- Requests while busy (including in EXC) are ignored, not queued.
- `abort` in CLR or RUN: IDLE at the next edge, no `HiLo_load`, no `done`; Hi/Lo keep their old values.
- `abort` in LOAD or EXC has no effect; the write or exception commits.
- `abort` in IDLE has no effect, and outranks a simultaneous request.
- Reset mid-operation: IDLE asynchronously; all outputs drop to 0 without waiting for a clock.

## Timing
- Reset values: state=IDLE, counter=0, op=DIV(0). All outputs 0.
- Request accepted at edge E0, with N = op cycle count:
  - cycle 1: CLR
  - cycles 2…N+1: RUN
  - cycle N+2: LOAD
  - cycle N+3: IDLE
- Hi/Lo update at the edge ending cycle N+2. Total latency is N+2 cycles; with defaults, 34.
- Run enables are high for exactly N cycles per op.
- Divide-by-zero: EXC in cycle 1, IDLE in cycle 2. `busy` is high for 1 cycle.
- The earliest next accept is at the edge ending the first IDLE cycle. There is no back-to-back accept from LOAD.
- `busy` rises in the cycle after the accept edge. The main controller must deassert its request once `busy` is seen.

## Structure
- Shared package (`cpu_pkg`) holds:
  - the state enum
  - op encoding OP_DIV=1'b0, OP_MULT=1'b1, matching the hi/lo mux select order
  - default cycle-count constants
- One sub-module: `muldiv_cycle_counter` (loadable CNT_W down-counter with a zero flag).
- FSM and output decode live in `muldiv_ctrl`.

## Test plan
- Multiply, defaults: `mult_req` pulse.
  - `unit_clr` for 1 cycle, then `mult_run` for 32 cycles.
  - Then `HiLo_load`=`done`=1 for 1 cycle, with `sel_mux_hi`=`sel_mux_lo`=1.
  - `busy` is high for 34 cycles.
- Divide, B≠0: `div_req` with `divisor_zero`=0.
  - `div_run` for 32 cycles, then `HiLo_load` with selects=0 in cycle 34; `div_zero` never asserts.
- Divide by zero: `div_req` with `divisor_zero`=1.
  - `div_zero` pulses in cycle 1; `busy` for 1 cycle.
  - No `unit_clr`, `div_run` or `HiLo_load`; selects keep their prior value.
- Simultaneous requests:
  - `mult_req`=`div_req`=1 gives a multiply (`mult_run`, selects=1).
  - `div_req` during RUN cycle 10 is ignored; exactly one `done` follows.
- Abort and reset:
  - `abort` at RUN cycle 5: IDLE at the next edge, no `HiLo_load`/`done`.
  - `abort` during LOAD: `HiLo_load` still asserted.
  - `reset` asserted mid-RUN, between edges: all outputs 0 immediately, IDLE after release.
- Parameter sweep: `MULT_CYCLES`=1, `DIV_CYCLES`=5 give exactly 1 and 5 RUN cycles (latency 3 and 7).
